// File: rtl/onedconv_row_scheduler.sv
// onedconv_row_scheduler: sequences one 1D convolution engine across an image, row by row
// Ports:
//   Clk, Reset          : rising-edge clock, synchronous active-high reset
//   Start, Abort        : frame request (sampled in IDLE) / cancel frame in progress
//   Width/Height/Ksize  : frame geometry W, H, K, latched on an IDLE Start
//   Src_Valid/Sink_Ready: pixel source and result sink handshake inputs
//   Src_Ready, Conv_*   : pixel accept, engine row clear / start / advance strobes
//   Out_Valid           : current beat yields a valid convolution result
//   Row/Col_Index       : current row and column
//   Busy, Done, Cfg_Err : status; Done and Cfg_Err are registered one-cycle pulses
// Optional: define ONEDCONV_ROW_SCHEDULER_STALL_CNT_EN to add the 32-bit Stall_Cnt output.
module onedconv_row_scheduler #(
  parameter int WIDTH_W  = 10,
  parameter int HEIGHT_W = 10,
  parameter int KSIZE_W  = 4
) (
  input  logic                ONEDCONV_ROW_SCHEDULER_Clk,
  input  logic                ONEDCONV_ROW_SCHEDULER_Reset,
  input  logic                ONEDCONV_ROW_SCHEDULER_Start,
  input  logic                ONEDCONV_ROW_SCHEDULER_Abort,
  input  logic [WIDTH_W-1:0]  ONEDCONV_ROW_SCHEDULER_Width,
  input  logic [HEIGHT_W-1:0] ONEDCONV_ROW_SCHEDULER_Height,
  input  logic [KSIZE_W-1:0]  ONEDCONV_ROW_SCHEDULER_Ksize,
  input  logic                ONEDCONV_ROW_SCHEDULER_Src_Valid,
  input  logic                ONEDCONV_ROW_SCHEDULER_Sink_Ready,
  output logic                ONEDCONV_ROW_SCHEDULER_Src_Ready,
  output logic                ONEDCONV_ROW_SCHEDULER_Conv_Row_Clr,
  output logic                ONEDCONV_ROW_SCHEDULER_Conv_Start,
  output logic                ONEDCONV_ROW_SCHEDULER_Conv_En,
  output logic                ONEDCONV_ROW_SCHEDULER_Out_Valid,
  output logic [HEIGHT_W-1:0] ONEDCONV_ROW_SCHEDULER_Row_Index,
  output logic [WIDTH_W-1:0]  ONEDCONV_ROW_SCHEDULER_Col_Index,
  output logic                ONEDCONV_ROW_SCHEDULER_Busy,
  output logic                ONEDCONV_ROW_SCHEDULER_Done,
  output logic                ONEDCONV_ROW_SCHEDULER_Cfg_Err
`ifdef ONEDCONV_ROW_SCHEDULER_STALL_CNT_EN
  ,
  output logic [31:0]         ONEDCONV_ROW_SCHEDULER_Stall_Cnt
`endif
);
  typedef enum logic [2:0] {IDLE, ROW_CLR, ROW_START, STREAM, ROW_END, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH_W-1:0] w_q;
  logic [HEIGHT_W-1:0] h_q;
  logic [KSIZE_W-1:0] k_q;
  logic cfg_bad, start_ok, beat, last_col, last_row;
  assign cfg_bad  = (ONEDCONV_ROW_SCHEDULER_Ksize == '0) | (ONEDCONV_ROW_SCHEDULER_Height == '0) |
                    (32'(ONEDCONV_ROW_SCHEDULER_Width) < 32'(ONEDCONV_ROW_SCHEDULER_Ksize));
  assign start_ok = (state == IDLE) & ONEDCONV_ROW_SCHEDULER_Start & ~cfg_bad;
  assign beat     = (state == STREAM) & ONEDCONV_ROW_SCHEDULER_Src_Valid & ONEDCONV_ROW_SCHEDULER_Sink_Ready;
  assign last_col = ONEDCONV_ROW_SCHEDULER_Col_Index == w_q - WIDTH_W'(1);
  assign last_row = ONEDCONV_ROW_SCHEDULER_Row_Index == h_q - HEIGHT_W'(1);
  assign ONEDCONV_ROW_SCHEDULER_Src_Ready   = (state == STREAM) & ONEDCONV_ROW_SCHEDULER_Sink_Ready;
  assign ONEDCONV_ROW_SCHEDULER_Conv_En     = beat;
  // col >= K-1 written as col+1 >= K so K==1 cannot underflow
  assign ONEDCONV_ROW_SCHEDULER_Out_Valid   = beat & (32'(ONEDCONV_ROW_SCHEDULER_Col_Index) + 32'd1 >= 32'(k_q));
  assign ONEDCONV_ROW_SCHEDULER_Conv_Row_Clr = state == ROW_CLR;
  assign ONEDCONV_ROW_SCHEDULER_Conv_Start  = state == ROW_START;
  assign ONEDCONV_ROW_SCHEDULER_Busy        = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start_ok ? ROW_CLR : IDLE;
      ROW_CLR:   state_nx = ROW_START;
      ROW_START: state_nx = STREAM;
      STREAM:    state_nx = (beat & last_col) ? ROW_END : STREAM;
      ROW_END:   state_nx = last_row ? DONE : ROW_CLR;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (ONEDCONV_ROW_SCHEDULER_Abort && state != IDLE) state_nx = IDLE;
  end
  always_ff @(posedge ONEDCONV_ROW_SCHEDULER_Clk) begin
    if (ONEDCONV_ROW_SCHEDULER_Reset) begin
      state <= IDLE;
      w_q <= '0;
      h_q <= '0;
      k_q <= '0;
      ONEDCONV_ROW_SCHEDULER_Row_Index <= '0;
      ONEDCONV_ROW_SCHEDULER_Col_Index <= '0;
      ONEDCONV_ROW_SCHEDULER_Done <= 1'b0;
      ONEDCONV_ROW_SCHEDULER_Cfg_Err <= 1'b0;
    end else begin
      state <= state_nx;
      ONEDCONV_ROW_SCHEDULER_Cfg_Err <= (state == IDLE) & ONEDCONV_ROW_SCHEDULER_Start & cfg_bad;
      // Done pulses the cycle after the DONE state; an abort there suppresses it
      ONEDCONV_ROW_SCHEDULER_Done <= (state == DONE) & ~ONEDCONV_ROW_SCHEDULER_Abort;
      if (state == IDLE && ONEDCONV_ROW_SCHEDULER_Start) begin
        w_q <= ONEDCONV_ROW_SCHEDULER_Width;
        h_q <= ONEDCONV_ROW_SCHEDULER_Height;
        k_q <= ONEDCONV_ROW_SCHEDULER_Ksize;
      end
      if (start_ok) ONEDCONV_ROW_SCHEDULER_Row_Index <= '0;
      else if (state == ROW_END && !last_row) ONEDCONV_ROW_SCHEDULER_Row_Index <= ONEDCONV_ROW_SCHEDULER_Row_Index + HEIGHT_W'(1);
      // the last column is held so the index never passes W-1
      if (state == ROW_CLR) ONEDCONV_ROW_SCHEDULER_Col_Index <= '0;
      else if (beat && !last_col) ONEDCONV_ROW_SCHEDULER_Col_Index <= ONEDCONV_ROW_SCHEDULER_Col_Index + WIDTH_W'(1);
    end
  end
`ifdef ONEDCONV_ROW_SCHEDULER_STALL_CNT_EN
  logic [31:0] stall_q;
  assign ONEDCONV_ROW_SCHEDULER_Stall_Cnt = stall_q;
  always_ff @(posedge ONEDCONV_ROW_SCHEDULER_Clk) begin
    if (ONEDCONV_ROW_SCHEDULER_Reset || start_ok) stall_q <= '0;
    else if (state == STREAM && !beat && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end
`endif
endmodule
